// File: rtl/irq_pending_ctrl.sv
// Pending/mask stage ahead of the 16-bit priority encoder, with a valid/ready index output.
// Optional macro IRQ_EDGE_DETECT_EN: rising-edge request capture plus a lost-request counter.
module irq_pending_ctrl #(
  parameter int unsigned N   = 16,
  parameter int unsigned IDW = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   mask_i,
  output logic [N-1:0]   enc_vec_o,
  input  logic [IDW-1:0] enc_idx_i,
  input  logic           enc_valid_i,
  output logic           irq_valid_o,
  output logic [IDW-1:0] irq_id_o,
  input  logic           irq_ready_i,
  input  logic           lost_clr_i,
  output logic [7:0]     lost_cnt_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   set_vec, clr_vec;
  logic           accept;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_valid_i) begin
          id_d    = enc_idx_i;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ready_i) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // Set is OR-ed in after the clear so a same-edge set keeps the bit pending.
  assign clr_vec   = accept ? ({{(N-1){1'b0}}, 1'b1} << id_q) : '0;
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign enc_vec_o   = pending_q & ~mask_i;
  assign irq_valid_o = (state_q == PRESENT);
  assign irq_id_o    = id_q;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N-1:0] req_q;
  logic [N-1:0] lost_vec;
  logic [IDW:0] lost_num;
  logic [8:0]   lost_sum;
  logic [7:0]   lost_q;

  assign set_vec  = req_i & ~req_q;
  assign lost_vec = set_vec & pending_q & ~clr_vec;

  always_comb begin
    lost_num = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lost_num = lost_num + {{IDW{1'b0}}, lost_vec[i]};
    end
  end

  assign lost_sum = {1'b0, lost_q} + {{(8 - IDW){1'b0}}, lost_num};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= '0;
      lost_q <= '0;
    end else begin
      req_q <= req_i;
      if (lost_clr_i) begin
        lost_q <= '0;
      end else if (lost_sum[8]) begin
        lost_q <= '1;
      end else begin
        lost_q <= lost_sum[7:0];
      end
    end
  end

  assign lost_cnt_o = lost_q;
`else
  logic unused_lost_clr;

  assign set_vec         = req_i;
  assign lost_cnt_o      = '0;
  assign unused_lost_clr = lost_clr_i;
`endif

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios plus random traffic against a cycle model.
// Honours IRQ_EDGE_DETECT_EN the same way the design does.
module tb_irq_pending_ctrl;

`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, mask, enc_vec;
  logic [3:0]  enc_idx, irq_id;
  logic        enc_valid, irq_valid, irq_ready, lost_clr;
  logic [7:0]  lost_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_pend[16];
  bit m_reqq[16];
  bit m_valid;
  int m_id;
  int m_lost;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.N(16), .IDW(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .mask_i      (mask),
    .enc_vec_o   (enc_vec),
    .enc_idx_i   (enc_idx),
    .enc_valid_i (enc_valid),
    .irq_valid_o (irq_valid),
    .irq_id_o    (irq_id),
    .irq_ready_i (irq_ready),
    .lost_clr_i  (lost_clr),
    .lost_cnt_o  (lost_cnt)
  );

  // Combinational encoder: highest set bit wins
  always_comb begin
    enc_valid = |enc_vec;
    enc_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (enc_vec[i]) enc_idx = 4'(i);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pend[i] = 1'b0;
      m_reqq[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_id    = 0;
    m_lost  = 0;
  endtask

  function automatic int model_vec();
    int v = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_pend[i] && !mask[i]) v += (1 << i);
    end
    return v;
  endfunction

  // Check current outputs against the model, then advance both by one clock.
  task automatic tick();
    bit np[16];
    bit acc, set, clr, n_valid;
    int ev, nlost, n_id, n_lost;
    #1;
    ev = model_vec();
    check("enc_vec", {16'h0, enc_vec}, ev);
    check("irq_valid", {31'h0, irq_valid}, {31'h0, m_valid});
    if (m_valid) check("irq_id", {28'h0, irq_id}, m_id);
    check("lost_cnt", {24'h0, lost_cnt}, m_lost);

    acc   = m_valid && irq_ready;
    nlost = 0;
    for (int i = 0; i < 16; i++) begin
      set = EDGE ? (req[i] && !m_reqq[i]) : req[i];
      clr = acc && (m_id == i);
      if (EDGE && set && m_pend[i] && !clr) nlost++;
      np[i] = set || (m_pend[i] && !clr);
    end
    if (!EDGE || lost_clr) n_lost = 0;
    else n_lost = (m_lost + nlost > 255) ? 255 : m_lost + nlost;

    n_valid = m_valid;
    n_id    = m_id;
    if (!m_valid) begin
      if (ev != 0) begin
        n_valid = 1'b1;
        for (int i = 0; i < 16; i++) if (ev[i]) n_id = i;
      end
    end else if (irq_ready) begin
      n_valid = 1'b0;
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      m_pend[i] = np[i];
      m_reqq[i] = req[i];
    end
    m_valid = n_valid;
    m_id    = n_id;
    m_lost  = n_lost;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // 1: reset held with all requests asserted
    rst_n = 1'b0; req = 16'hFFFF; mask = '0; irq_ready = 1'b0; lost_clr = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_valid", {31'h0, irq_valid}, 0);
      check("rst_vec", {16'h0, enc_vec}, 0);
      check("rst_lost", {24'h0, lost_cnt}, 0);
    end
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks(2);

    // 2: single pulse on line 4, then accept
    req = 16'h0010;
    tick();
    req = '0;
    check("t2_vec", {16'h0, enc_vec}, 32'h10);
    check("t2_valid_c1", {31'h0, irq_valid}, 0);
    tick();
    check("t2_valid", {31'h0, irq_valid}, 1);
    check("t2_id", {28'h0, irq_id}, 4);
    irq_ready = 1'b1;
    tick();
    check("t2_done_valid", {31'h0, irq_valid}, 0);
    check("t2_done_vec", {16'h0, enc_vec}, 0);

    // 3: two lines, ready high: 8 first, idle gap, then 0
    req = 16'h0101;
    tick();
    req = '0;
    tick();
    check("t3_id8", {28'h0, irq_id}, 8);
    check("t3_v8", {31'h0, irq_valid}, 1);
    tick();
    check("t3_gap", {31'h0, irq_valid}, 0);
    tick();
    check("t3_id0", {28'h0, irq_id}, 0);
    check("t3_v0", {31'h0, irq_valid}, 1);
    tick();
    check("t3_idle", {31'h0, irq_valid}, 0);
    ticks(2);

    // 4: masked line pends silently, presented once unmasked
    mask = 16'h0001; req = 16'h0001;
    tick();
    req = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_masked_vec", {16'h0, enc_vec}, 0);
      check("t4_masked_valid", {31'h0, irq_valid}, 0);
    end
    irq_ready = 1'b0; mask = '0;
    ticks(2);
    check("t4_valid", {31'h0, irq_valid}, 1);
    check("t4_id", {28'h0, irq_id}, 0);
    irq_ready = 1'b1;
    ticks(2);

    // 5: repeated pulses on a pending line while the consumer stalls
    irq_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req = 16'h0002; tick();
      req = '0;       tick();
    end
    check("t5_id", {28'h0, irq_id}, 1);
    check("t5_lost", {24'h0, lost_cnt}, EDGE ? 2 : 0);
    lost_clr = 1'b1; tick();
    lost_clr = 1'b0;
    check("t5_clr", {24'h0, lost_cnt}, 0);
    irq_ready = 1'b1;
    ticks(3);
    check("t5_drained", {31'h0, irq_valid}, 0);

    // Saturation and clear-beats-increment on the lost counter
    irq_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      req = 16'hFFFF; tick();
      req = '0;       tick();
    end
    check("sat_lost", {24'h0, lost_cnt}, EDGE ? 255 : 0);
    req = 16'hFFFF; lost_clr = 1'b1; tick();
    req = '0; lost_clr = 1'b0;
    check("clr_wins", {24'h0, lost_cnt}, 0);
    irq_ready = 1'b1;
    ticks(40);

    // 6: async reset while presenting id 4
    irq_ready = 1'b0; mask = '0;
    req = 16'h0010; tick();
    req = '0;       ticks(2);
    check("t6_pre_valid", {31'h0, irq_valid}, 1);
    check("t6_pre_id", {28'h0, irq_id}, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'h0, irq_valid}, 0);
    check("t6_async_vec", {16'h0, enc_vec}, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks(4);
    check("t6_no_repeat", {31'h0, irq_valid}, 0);

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      req       = 16'($urandom & $urandom & $urandom);
      mask      = 16'($urandom & $urandom);
      irq_ready = ($urandom_range(0, 3) != 0);
      lost_clr  = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
